// File: rtl/pong_pkg.sv
// Shared constants and state encoding for the pong design.
package pong_pkg;

  localparam int SCORE_W         = 5;
  localparam int MAX_SCORE_LIMIT = 31;
  localparam int HOLD_W          = 8;
  localparam int H_SCREEN        = 640;
  localparam int V_SCREEN        = 480;

  typedef enum logic [2:0] {
    ST_MENU      = 3'd0,
    ST_SET       = 3'd1,
    ST_START     = 3'd2,
    ST_PLAY      = 3'd3,
    ST_END_POINT = 3'd4,
    ST_END_GAME  = 3'd5
  } game_state_t;

  // One saturating step of the winning score; opposite buttons cancel.
  function automatic logic [SCORE_W-1:0] max_step(input logic [SCORE_W-1:0] cur,
                                                   input logic up,
                                                   input logic down);
    logic [SCORE_W-1:0] nxt;
    nxt = cur;
    if (up && !down && (cur < SCORE_W'(MAX_SCORE_LIMIT)))
      nxt = cur + SCORE_W'(1);
    else if (down && !up && (cur > SCORE_W'(1)))
      nxt = cur - SCORE_W'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser followed by a rising-edge detector.
// press is high for exactly one clk per button press.
module btn_edge
  import pong_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic press
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchroniser chain plus one-clk history for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = sync2 & ~prev;

endmodule

// File: rtl/game_sequencer.sv
// Pong game controller: menu, winning-score setup, serve, rally and
// end-of-point / end-of-game hold phases.
//
// state      | meaning
// -----------+-----------------------------------------------
// MENU       | choose set-score or quick start
// SET        | adjust winning score with up/down
// START      | ball parked at serve position, wait for launch
// PLAY       | ball moving, waiting for a wall hit
// END_POINT  | hold POINT_HOLD frames, then serve again
// END_GAME   | hold GAME_HOLD frames (or launch), then MENU
module game_sequencer
  import pong_pkg::*;
#(
  parameter int MAX_DEFAULT = 5,
  parameter int POINT_HOLD  = 60,
  parameter int GAME_HOLD   = 180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               btn_launch,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               left_hit,
  input  logic               right_hit,
  output logic [2:0]         state,
  output logic               menu_sel,
  output logic [SCORE_W-1:0] max_score,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               serve_side,
  output logic               ball_reset,
  output logic               play_en,
  output logic               winner
);

  logic launch;
  logic up;
  logic down;

  btn_edge u_launch (.clk(clk), .reset(reset), .btn_in(btn_launch), .press(launch));
  btn_edge u_up     (.clk(clk), .reset(reset), .btn_in(btn_up),     .press(up));
  btn_edge u_down   (.clk(clk), .reset(reset), .btn_in(btn_down),   .press(down));

  game_state_t        state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               menu_sel_d;
  logic [SCORE_W-1:0] max_score_d;
  logic [SCORE_W-1:0] score_p1_d;
  logic [SCORE_W-1:0] score_p2_d;
  logic               serve_side_d;
  logic               winner_d;
  logic               ball_reset_d;
  logic               play_en_d;
  logic [SCORE_W-1:0] p1_inc;
  logic [SCORE_W-1:0] p2_inc;

  assign p1_inc = score_p1 + SCORE_W'(1);
  assign p2_inc = score_p2 + SCORE_W'(1);
  assign state  = state_q;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    menu_sel_d   = menu_sel;
    max_score_d  = max_score;
    score_p1_d   = score_p1;
    score_p2_d   = score_p2;
    serve_side_d = serve_side;
    winner_d     = winner;

    case (state_q)
      ST_MENU: begin
        if (up)
          menu_sel_d = 1'b0;
        else if (down)
          menu_sel_d = 1'b1;
        if (launch) begin
          if (menu_sel) begin
            state_d      = ST_START;
            score_p1_d   = '0;
            score_p2_d   = '0;
            serve_side_d = 1'b0;
          end else begin
            state_d = ST_SET;
          end
        end
      end
      ST_SET: begin
        max_score_d = max_step(max_score, up, down);
        if (launch) begin
          state_d      = ST_START;
          score_p1_d   = '0;
          score_p2_d   = '0;
          serve_side_d = 1'b0;
        end
      end
      ST_START: begin
        if (launch)
          state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // left_hit wins a simultaneous hit.
        if (left_hit) begin
          score_p2_d   = p2_inc;
          serve_side_d = 1'b0;
          if (p2_inc == max_score) begin
            state_d  = ST_END_GAME;
            winner_d = 1'b1;
          end else begin
            state_d = ST_END_POINT;
          end
        end else if (right_hit) begin
          score_p1_d   = p1_inc;
          serve_side_d = 1'b1;
          if (p1_inc == max_score) begin
            state_d  = ST_END_GAME;
            winner_d = 1'b0;
          end else begin
            state_d = ST_END_POINT;
          end
        end
      end
      ST_END_POINT: begin
        if (frame_tick)
          hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_W'(POINT_HOLD))
          state_d = ST_START;
      end
      ST_END_GAME: begin
        if (frame_tick)
          hold_d = hold_q + HOLD_W'(1);
        if (launch || (hold_q == HOLD_W'(GAME_HOLD)))
          state_d = ST_MENU;
      end
      default: state_d = ST_MENU;
    endcase

    if (state_d != state_q)
      hold_d = '0;

    ball_reset_d = (state_d == ST_START) && (state_q != ST_START);
    play_en_d    = (state_d == ST_PLAY);
  end

  // State, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_MENU;
      hold_q     <= '0;
      menu_sel   <= 1'b0;
      max_score  <= SCORE_W'(MAX_DEFAULT);
      score_p1   <= '0;
      score_p2   <= '0;
      serve_side <= 1'b0;
      ball_reset <= 1'b0;
      play_en    <= 1'b0;
      winner     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      menu_sel   <= menu_sel_d;
      max_score  <= max_score_d;
      score_p1   <= score_p1_d;
      score_p2   <= score_p2_d;
      serve_side <= serve_side_d;
      ball_reset <= ball_reset_d;
      play_en    <= play_en_d;
      winner     <= winner_d;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with hand-computed expectations.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       btn_launch;
  logic       btn_up;
  logic       btn_down;
  logic       left_hit;
  logic       right_hit;
  logic [2:0] state;
  logic       menu_sel;
  logic [4:0] max_score;
  logic [4:0] score_p1;
  logic [4:0] score_p2;
  logic       serve_side;
  logic       ball_reset;
  logic       play_en;
  logic       winner;

  int tests = 0;
  int fails = 0;

  game_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_launch(btn_launch), .btn_up(btn_up), .btn_down(btn_down),
    .left_hit(left_hit), .right_hit(right_hit),
    .state(state), .menu_sel(menu_sel), .max_score(max_score),
    .score_p1(score_p1), .score_p2(score_p2), .serve_side(serve_side),
    .ball_reset(ball_reset), .play_en(play_en), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // which: 0 = launch, 1 = up, 2 = down. Returns on the clk the action lands.
  task automatic press(input int which);
    tick(2);
    case (which)
      0: btn_launch = 1'b1;
      1: btn_up     = 1'b1;
      default: btn_down = 1'b1;
    endcase
    tick(3);
    btn_launch = 1'b0;
    btn_up     = 1'b0;
    btn_down   = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      tick(1);
      frame_tick = 1'b0;
      tick(1);
    end
  endtask

  task automatic pulse_hit(input logic l, input logic r);
    left_hit  = l;
    right_hit = r;
    tick(1);
    left_hit  = 1'b0;
    right_hit = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; btn_launch = 1'b0; btn_up = 1'b0;
    btn_down = 1'b0; left_hit = 1'b0; right_hit = 1'b0;
    tick(2);
    chk("rst_state", state, 0);
    chk("rst_menu_sel", menu_sel, 0);
    chk("rst_max", max_score, 5);
    chk("rst_p1", score_p1, 0);
    chk("rst_p2", score_p2, 0);
    chk("rst_serve", serve_side, 0);
    chk("rst_ball_reset", ball_reset, 0);
    chk("rst_play_en", play_en, 0);
    chk("rst_winner", winner, 0);
    reset = 1'b0;
    tick(1);

    // Menu: up keeps set-score, launch enters SET with 3 clk latency.
    press(1);
    chk("menu_up_sel", menu_sel, 0);
    tick(2);
    btn_launch = 1'b1;
    tick(2);
    chk("launch_lat_2clk", state, 0);
    tick(1);
    chk("launch_lat_3clk", state, 1);
    btn_launch = 1'b0;

    // SET: 5 +3 -1 = 7.
    press(1); press(1); press(1); press(2);
    chk("set_max_7", max_score, 7);
    press(0);
    chk("set_to_start", state, 2);
    chk("start_ball_reset", ball_reset, 1);
    chk("start_p1_clr", score_p1, 0);
    tick(1);
    chk("ball_reset_1clk", ball_reset, 0);

    // Hit in START is ignored.
    pulse_hit(1'b0, 1'b1);
    chk("start_hit_p1", score_p1, 0);
    chk("start_hit_state", state, 2);

    // Simultaneous hits: only left counts.
    press(0);
    chk("play_state", state, 3);
    chk("play_en_hi", play_en, 1);
    pulse_hit(1'b1, 1'b1);
    chk("both_p2", score_p2, 1);
    chk("both_p1", score_p1, 0);
    chk("both_serve", serve_side, 0);
    chk("both_state", state, 4);
    chk("both_play_en", play_en, 0);

    // Hit in END_POINT ignored; hold lasts 60 ticks.
    pulse_hit(1'b0, 1'b1);
    chk("endpt_hit_p1", score_p1, 0);
    frames(59);
    chk("endpt_59", state, 4);
    frames(1);
    chk("endpt_60", state, 2);
    chk("endpt_ball_reset", ball_reset, 1);

    // Reset mid-PLAY with a pending hit.
    press(0);
    chk("play2_state", state, 3);
    reset = 1'b1;
    right_hit = 1'b1;
    tick(1);
    reset = 1'b0;
    right_hit = 1'b0;
    chk("midrst_state", state, 0);
    chk("midrst_max", max_score, 5);
    chk("midrst_p1", score_p1, 0);
    chk("midrst_p2", score_p2, 0);
    chk("midrst_play_en", play_en, 0);
    tick(1);

    // Quick start, right player wins 5-0.
    press(2);
    chk("menu_down_sel", menu_sel, 1);
    press(0);
    chk("quick_state", state, 2);
    chk("quick_serve", serve_side, 0);
    for (int i = 1; i <= 4; i++) begin
      press(0);
      chk("rally_play_en", play_en, 1);
      pulse_hit(1'b0, 1'b1);
      chk("rally_p1", score_p1, i);
      chk("rally_serve", serve_side, 1);
      chk("rally_state", state, 4);
      frames(60);
      chk("rally_back_start", state, 2);
    end
    press(0);
    pulse_hit(1'b0, 1'b1);
    chk("game_state", state, 5);
    chk("game_winner", winner, 0);
    chk("game_p1", score_p1, 5);

    // END_GAME times out after 180 ticks; scores hold.
    frames(179);
    chk("endgame_179", state, 5);
    frames(1);
    chk("endgame_180", state, 0);
    chk("endgame_p1_hold", score_p1, 5);
    pulse_hit(1'b0, 1'b1);
    chk("menu_hit_p1", score_p1, 5);

    // Saturation in SET.
    press(1);
    chk("menu_up_clr", menu_sel, 0);
    press(0);
    chk("enter_set", state, 1);
    for (int i = 0; i < 40; i++) press(1);
    chk("sat_hi", max_score, 31);
    for (int i = 0; i < 40; i++) press(2);
    chk("sat_lo", max_score, 1);
    tick(2);
    btn_up = 1'b1;
    tick(1000);
    btn_up = 1'b0;
    chk("hold_one_step", max_score, 2);
    tick(2);
    btn_up = 1'b1;
    btn_down = 1'b1;
    tick(3);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(2);
    chk("up_down_cancel", max_score, 2);

    // New game from SET clears scores; left player wins 0-2.
    press(0);
    chk("set_clr_p1", score_p1, 0);
    chk("set_clr_serve", serve_side, 0);
    press(0);
    pulse_hit(1'b1, 1'b0);
    chk("left_p2", score_p2, 1);
    chk("left_state", state, 4);
    frames(60);
    press(0);
    pulse_hit(1'b1, 1'b0);
    chk("left_game_state", state, 5);
    chk("left_winner", winner, 1);
    chk("left_p2_final", score_p2, 2);

    // Launch skips the END_GAME hold.
    tick(2);
    btn_launch = 1'b1;
    tick(2);
    chk("skip_2clk", state, 5);
    tick(1);
    chk("skip_3clk", state, 0);
    btn_launch = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
